// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK flip-flops with per-bit JK control plus up/down toggle-chain counting
// and parallel load; registered terminal-count and change-detect flags.
module jk_counter_bank #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 SATURATE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             changed
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] up_toggle;
  logic [WIDTH-1:0] down_toggle;
  logic             all_ones;
  logic             all_zero;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] next_q;
  logic             next_tc;

  assign mode_sel = mode_e'(mode);
  assign q_n      = ~q;

  // Toggle chains: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_toggle      = '0;
    down_toggle    = '0;
    up_toggle[0]   = 1'b1;
    down_toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_toggle[i]   = up_toggle[i-1] & q[i-1];
      down_toggle[i] = down_toggle[i-1] & ~q[i-1];
    end
  end

  assign all_ones = up_toggle[WIDTH-1] & q[WIDTH-1];
  assign all_zero = down_toggle[WIDTH-1] & ~q[WIDTH-1];
  assign jk_next  = (j & ~q) | (~k & q);

  always_comb begin
    next_q  = q;
    next_tc = 1'b0;
    unique case (mode_sel)
      MODE_JK: begin
        next_q = jk_next;
      end
      MODE_UP: begin
        next_tc = all_ones;
        if (!(all_ones && (SATURATE != 0))) begin
          next_q = q ^ up_toggle;
        end
      end
      MODE_DOWN: begin
        next_tc = all_zero;
        if (!(all_zero && (SATURATE != 0))) begin
          next_q = q ^ down_toggle;
        end
      end
      MODE_LOAD: begin
        next_q = j;
      end
      default: begin
        next_q = q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VALUE;
      tc      <= 1'b0;
      changed <= 1'b0;
    end else if (en) begin
      q       <= next_q;
      tc      <= next_tc;
      changed <= (next_q != q);
    end else begin
      tc      <= 1'b0;
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Scoreboard bench for jk_counter_bank: a wrapping and a saturating instance share stimulus;
// expected {q, tc, changed} are queued per edge and compared after the edge.
module tb_jk_counter_bank;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       changed;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q0, qn0, q1, qn1;
  logic       tc0, ch0, tc1, ch1;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   passed;
  int   total;

  jk_counter_bank #(.WIDTH(4), .RESET_VALUE(4'h5), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .q(q0), .q_n(qn0), .tc(tc0), .changed(ch0)
  );

  jk_counter_bank #(.WIDTH(4), .RESET_VALUE(4'h5), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .q(q1), .q_n(qn1), .tc(tc1), .changed(ch1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge; inputs settle, one rising edge passes, returns at the next falling edge.
  task automatic drive_edge(input logic e, input logic [1:0] m, input logic [3:0] jj, input logic [3:0] kk);
    en   = e;
    mode = m;
    j    = jj;
    k    = kk;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    j     = 4'h0;
    k     = 4'h0;
    repeat (10) @(negedge clk);
    total++;
    if ({q0, qn0, tc0, ch0} !== {4'h5, 4'hA, 1'b0, 1'b0})
      $display("[TB] FAIL reset_wrap: got q=%h q_n=%h tc=%b changed=%b, want q=5 q_n=a tc=0 changed=0", q0, qn0, tc0, ch0);
    else passed++;
    total++;
    if ({q1, qn1, tc1, ch1} !== {4'h5, 4'hA, 1'b0, 1'b0})
      $display("[TB] FAIL reset_sat: got q=%h q_n=%h tc=%b changed=%b, want q=5 q_n=a tc=0 changed=0", q1, qn1, tc1, ch1);
    else passed++;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sb0.push_back('{q: 4'h5, tc: 1'b0, changed: 1'b0});
      drive_edge(1'b0, 2'b01, 4'h0, 4'h0);
      e0 = sb0.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL en_low_hold[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
    end
  endtask

  task automatic test_jk();
    logic [3:0] jv[6] = '{4'h0, 4'hF, 4'h0, 4'hA, 4'h3, 4'h0};
    logic [3:0] kv[6] = '{4'h0, 4'h0, 4'hF, 4'hA, 4'hC, 4'h0};
    logic [1:0] mv[6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_t       ev[6] = '{'{4'h0, 1'b0, 1'b1}, '{4'hF, 1'b0, 1'b1}, '{4'h0, 1'b0, 1'b1},
                          '{4'hA, 1'b0, 1'b1}, '{4'h3, 1'b0, 1'b1}, '{4'h3, 1'b0, 1'b0}};
    for (int s = 0; s < 6; s++) begin
      sb0.push_back(ev[s]);
      sb1.push_back(ev[s]);
      drive_edge(1'b1, mv[s], jv[s], kv[s]);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL jk_wrap[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
      total++;
      if ({q1, tc1, ch1} !== e1)
        $display("[TB] FAIL jk_sat[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q1, tc1, ch1, e1.q, e1.tc, e1.changed);
      else passed++;
    end
    total++;
    if (qn0 !== 4'hC)
      $display("[TB] FAIL jk_q_n: got q_n=%h, want q_n=c", qn0);
    else passed++;
  endtask

  task automatic test_count_up();
    logic [1:0] mv[4] = '{2'b11, 2'b01, 2'b01, 2'b01};
    exp_t w[4] = '{'{4'hE, 1'b0, 1'b1}, '{4'hF, 1'b0, 1'b1}, '{4'h0, 1'b1, 1'b1}, '{4'h1, 1'b0, 1'b1}};
    exp_t h[4] = '{'{4'hE, 1'b0, 1'b1}, '{4'hF, 1'b0, 1'b1}, '{4'hF, 1'b1, 1'b0}, '{4'hF, 1'b1, 1'b0}};
    for (int s = 0; s < 4; s++) begin
      sb0.push_back(w[s]);
      sb1.push_back(h[s]);
      drive_edge(1'b1, mv[s], 4'hE, 4'h0);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL up_wrap[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
      total++;
      if ({q1, tc1, ch1} !== e1)
        $display("[TB] FAIL up_sat[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q1, tc1, ch1, e1.q, e1.tc, e1.changed);
      else passed++;
    end
  endtask

  task automatic test_count_down();
    logic [1:0] mv[4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    exp_t w[4] = '{'{4'h1, 1'b0, 1'b0}, '{4'h0, 1'b0, 1'b1}, '{4'hF, 1'b1, 1'b1}, '{4'hE, 1'b0, 1'b1}};
    exp_t h[4] = '{'{4'h1, 1'b0, 1'b1}, '{4'h0, 1'b0, 1'b1}, '{4'h0, 1'b1, 1'b0}, '{4'h0, 1'b1, 1'b0}};
    for (int s = 0; s < 4; s++) begin
      sb0.push_back(w[s]);
      sb1.push_back(h[s]);
      drive_edge(1'b1, mv[s], 4'h1, 4'hF);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL down_wrap[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
      total++;
      if ({q1, tc1, ch1} !== e1)
        $display("[TB] FAIL down_sat[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q1, tc1, ch1, e1.q, e1.tc, e1.changed);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] want;
    sb0.push_back('{q: 4'h0, tc: 1'b0, changed: 1'b1});
    drive_edge(1'b1, 2'b11, 4'h0, 4'h0);
    e0 = sb0.pop_front();
    total++;
    if ({q0, tc0, ch0} !== e0)
      $display("[TB] FAIL arst_load: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", q0, tc0, ch0, e0.q, e0.tc, e0.changed);
    else passed++;
    want = 4'h0;
    for (int s = 0; s < 6; s++) begin
      want = want + 4'h1;
      sb0.push_back('{q: want, tc: 1'b0, changed: 1'b1});
      drive_edge(1'b1, 2'b01, 4'h0, 4'h0);
      e0 = sb0.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL arst_count[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({q0, tc0, ch0} !== {4'h5, 1'b0, 1'b0})
      $display("[TB] FAIL arst_immediate: got q=%h tc=%b changed=%b, want q=5 tc=0 changed=0", q0, tc0, ch0);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({q0, tc0, ch0} !== {4'h5, 1'b0, 1'b0})
      $display("[TB] FAIL arst_held: got q=%h tc=%b changed=%b, want q=5 tc=0 changed=0", q0, tc0, ch0);
    else passed++;
    reset = 1'b1;
    sb0.push_back('{q: 4'h6, tc: 1'b0, changed: 1'b1});
    drive_edge(1'b1, 2'b01, 4'h0, 4'h0);
    e0 = sb0.pop_front();
    total++;
    if ({q0, tc0, ch0} !== e0)
      $display("[TB] FAIL arst_release: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", q0, tc0, ch0, e0.q, e0.tc, e0.changed);
    else passed++;
  endtask

  task automatic test_en_toggle();
    logic       ev_en[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] mv[6]    = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    exp_t w[6] = '{'{4'hE, 1'b0, 1'b1}, '{4'hF, 1'b0, 1'b1}, '{4'h0, 1'b1, 1'b1},
                   '{4'h0, 1'b0, 1'b0}, '{4'h1, 1'b0, 1'b1}, '{4'h1, 1'b0, 1'b0}};
    exp_t h[6] = '{'{4'hE, 1'b0, 1'b1}, '{4'hF, 1'b0, 1'b1}, '{4'hF, 1'b1, 1'b0},
                   '{4'hF, 1'b0, 1'b0}, '{4'hF, 1'b1, 1'b0}, '{4'hF, 1'b0, 1'b0}};
    for (int s = 0; s < 6; s++) begin
      sb0.push_back(w[s]);
      sb1.push_back(h[s]);
      drive_edge(ev_en[s], mv[s], 4'hE, 4'h0);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL en_wrap[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
      total++;
      if ({q1, tc1, ch1} !== e1)
        $display("[TB] FAIL en_sat[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q1, tc1, ch1, e1.q, e1.tc, e1.changed);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] mv[5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [3:0] jv[5] = '{4'h3, 4'h0, 4'h0, 4'hF, 4'h7};
    logic [3:0] kv[5] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h9};
    exp_t w[5] = '{'{4'h3, 1'b0, 1'b1}, '{4'h4, 1'b0, 1'b1}, '{4'h3, 1'b0, 1'b1},
                   '{4'hC, 1'b0, 1'b1}, '{4'h7, 1'b0, 1'b1}};
    for (int s = 0; s < 5; s++) begin
      sb0.push_back(w[s]);
      drive_edge(1'b1, mv[s], jv[s], kv[s]);
      e0 = sb0.pop_front();
      total++;
      if ({q0, tc0, ch0} !== e0)
        $display("[TB] FAIL b2b[%0d]: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", s, q0, tc0, ch0, e0.q, e0.tc, e0.changed);
      else passed++;
    end
    sb0.push_back('{q: 4'h7, tc: 1'b0, changed: 1'b0});
    drive_edge(1'b1, 2'b11, 4'h7, 4'h0);
    e0 = sb0.pop_front();
    total++;
    if ({q0, tc0, ch0} !== e0)
      $display("[TB] FAIL b2b_same_load: got q=%h tc=%b changed=%b, want q=%h tc=%b changed=%b", q0, tc0, ch0, e0.q, e0.tc, e0.changed);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_async_reset();
    test_en_toggle();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
